// File: rtl/efi_pulse_scheduler.sv
// efi_pulse_scheduler
// Turns the stroke FSM's injection and ignition windows into one timed drive
// pulse per window. Channel 0 is the injector, channel 1 the ignition coil.
// Both channels run the same FSM: IDLE -> (WAIT) -> PULSE -> DONE -> IDLE.
// The start of the pulse is counted in crank ticks. The length of the pulse
// is counted in clock cycles.
`timescale 1ns/1ps

module efi_pulse_scheduler #(
    parameter int TICK_W = 8,
    parameter int PW_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              on,
    input  logic              crank_tick,
    input  logic [1:0]        stroke,
    input  logic              allow_injection,
    input  logic              allow_ignition,
    input  logic [TICK_W-1:0] inj_delay,
    input  logic [PW_W-1:0]   inj_width,
    input  logic [TICK_W-1:0] ign_delay,
    input  logic [PW_W-1:0]   ign_dwell,
    output logic              inj_out,
    output logic              ign_out,
    output logic              inj_busy,
    output logic              ign_busy,
    output logic              inj_missed,
    output logic              ign_missed,
    output logic              stroke_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] STROKE_INTAKE     = 2'b00;
    localparam logic [1:0] STROKE_COMBUSTION = 2'b10;

    // Per-channel views of the inputs, so both channels share one generate body.
    logic [1:0]        allow_vec;
    logic [1:0]        allow_prev_reg;
    logic [1:0]        rise_vec;
    logic [1:0]        stroke_ok_vec;
    logic [TICK_W-1:0] delay_vec [2];
    logic [PW_W-1:0]   width_vec [2];
    logic              stroke_err_reg;

    assign allow_vec     = {allow_ignition, allow_injection};
    assign rise_vec      = allow_vec & ~allow_prev_reg;
    assign stroke_ok_vec = {(stroke == STROKE_COMBUSTION), (stroke == STROKE_INTAKE)};
    assign delay_vec[0]  = inj_delay;
    assign delay_vec[1]  = ign_delay;
    assign width_vec[0]  = inj_width;
    assign width_vec[1]  = ign_dwell;

    // Track the previous window level every cycle. This runs even while the
    // block is disabled, so that turning it back on does not fake an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            allow_prev_reg <= 2'b00;
        end else begin
            allow_prev_reg <= allow_vec;
        end
    end

    // Flag a window opening in the wrong stroke. A bad edge on both channels
    // in the same cycle still raises only one strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stroke_err_reg <= 1'b0;
        end else begin
            stroke_err_reg <= |(rise_vec & ~stroke_ok_vec);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [1:0]        state_reg, state_next;
            logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
            logic [PW_W-1:0]   width_cnt_reg, width_cnt_next;
            logic [PW_W-1:0]   shadow_width_reg, shadow_width_next;
            logic              out_reg;
            logic              missed_reg, missed_next;

            // Channel FSM. The tick counter is loaded straight from the delay
            // input when the channel arms, so it acts as the delay shadow.
            always_comb begin
                state_next        = state_reg;
                tick_cnt_next     = tick_cnt_reg;
                width_cnt_next    = width_cnt_reg;
                shadow_width_next = shadow_width_reg;
                missed_next       = 1'b0;
                if (!on) begin
                    state_next     = ST_IDLE;
                    tick_cnt_next  = '0;
                    width_cnt_next = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (rise_vec[gi] && stroke_ok_vec[gi]) begin
                                shadow_width_next = width_vec[gi];
                                if (width_vec[gi] == '0) begin
                                    state_next = ST_DONE;
                                end else if (delay_vec[gi] == '0) begin
                                    state_next     = ST_PULSE;
                                    width_cnt_next = width_vec[gi];
                                end else begin
                                    state_next    = ST_WAIT;
                                    tick_cnt_next = delay_vec[gi];
                                end
                            end
                        end
                        ST_WAIT: begin
                            // A closed window wins over a tick in the same cycle.
                            if (!allow_vec[gi]) begin
                                state_next    = ST_IDLE;
                                tick_cnt_next = '0;
                                missed_next   = 1'b1;
                            end else if (crank_tick) begin
                                if (tick_cnt_reg <= TICK_W'(1)) begin
                                    state_next     = ST_PULSE;
                                    tick_cnt_next  = '0;
                                    width_cnt_next = shadow_width_reg;
                                end else begin
                                    tick_cnt_next = tick_cnt_reg - TICK_W'(1);
                                end
                            end
                        end
                        ST_PULSE: begin
                            // The pulse always runs to full width, even if the
                            // window closes during it.
                            if (width_cnt_reg <= PW_W'(1)) begin
                                state_next     = ST_DONE;
                                width_cnt_next = '0;
                            end else begin
                                width_cnt_next = width_cnt_reg - PW_W'(1);
                            end
                        end
                        default: begin
                            // DONE: stay here until the window closes, so
                            // there is only one pulse per window.
                            if (!allow_vec[gi]) begin
                                state_next = ST_IDLE;
                            end
                        end
                    endcase
                end
            end

            // Channel registers. The drive output is registered from the
            // next state, so it rises in the same cycle as PULSE is entered.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg        <= ST_IDLE;
                    tick_cnt_reg     <= '0;
                    width_cnt_reg    <= '0;
                    shadow_width_reg <= '0;
                    out_reg          <= 1'b0;
                    missed_reg       <= 1'b0;
                end else begin
                    state_reg        <= state_next;
                    tick_cnt_reg     <= tick_cnt_next;
                    width_cnt_reg    <= width_cnt_next;
                    shadow_width_reg <= shadow_width_next;
                    out_reg          <= (state_next == ST_PULSE);
                    missed_reg       <= missed_next;
                end
            end
        end
    endgenerate

    assign inj_out    = g_ch[0].out_reg;
    assign ign_out    = g_ch[1].out_reg;
    assign inj_busy   = (g_ch[0].state_reg != ST_IDLE);
    assign ign_busy   = (g_ch[1].state_reg != ST_IDLE);
    assign inj_missed = g_ch[0].missed_reg;
    assign ign_missed = g_ch[1].missed_reg;
    assign stroke_err = stroke_err_reg;

endmodule

// File: tb/tb_efi_pulse_scheduler.sv
// Directed bench for efi_pulse_scheduler. Inputs change 1ns after the rising
// edge, and outputs are checked at that same point.
`timescale 1ns/1ps

module tb_efi_pulse_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        on;
    logic        crank_tick;
    logic [1:0]  stroke;
    logic        allow_injection;
    logic        allow_ignition;
    logic [7:0]  inj_delay;
    logic [15:0] inj_width;
    logic [7:0]  ign_delay;
    logic [15:0] ign_dwell;
    logic        inj_out, ign_out, inj_busy, ign_busy;
    logic        inj_missed, ign_missed, stroke_err;

    int vectors     = 0;
    int miscompares = 0;

    efi_pulse_scheduler #(.TICK_W(8), .PW_W(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .on              (on),
        .crank_tick      (crank_tick),
        .stroke          (stroke),
        .allow_injection (allow_injection),
        .allow_ignition  (allow_ignition),
        .inj_delay       (inj_delay),
        .inj_width       (inj_width),
        .ign_delay       (ign_delay),
        .ign_dwell       (ign_dwell),
        .inj_out         (inj_out),
        .ign_out         (ign_out),
        .inj_busy        (inj_busy),
        .ign_busy        (ign_busy),
        .inj_missed      (inj_missed),
        .ign_missed      (ign_missed),
        .stroke_err      (stroke_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait some idle cycles, then present one crank tick to the next edge.
    task automatic tick_after(input int idle);
        repeat (idle) step();
        crank_tick = 1'b1;
        step();
        crank_tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; on = 1'b1; crank_tick = 1'b0; stroke = 2'b00;
        allow_injection = 1'b0; allow_ignition = 1'b0;
        inj_delay = 8'd0; inj_width = 16'd0; ign_delay = 8'd0; ign_dwell = 16'd0;
        step(); step();

        // Reset state
        check("rst_inj_out", inj_out, 0);
        check("rst_ign_out", ign_out, 0);
        check("rst_inj_busy", inj_busy, 0);
        check("rst_ign_busy", ign_busy, 0);
        check("rst_inj_missed", inj_missed, 0);
        check("rst_ign_missed", ign_missed, 0);
        check("rst_stroke_err", stroke_err, 0);
        reset_n = 1'b1;
        repeat (3) step();

        // Basic injection: delay 3 ticks, width 10
        inj_delay = 8'd3; inj_width = 16'd10; stroke = 2'b00;
        allow_injection = 1'b1;
        step();
        check("basic_busy", inj_busy, 1);
        check("basic_wait_out", inj_out, 0);
        tick_after(19);
        tick_after(19);
        check("basic_pre_out", inj_out, 0);
        tick_after(19);
        for (int i = 0; i < 10; i++) begin
            check("basic_pulse", inj_out, 1);
            check("basic_no_missed", inj_missed, 0);
            step();
        end
        check("basic_end_out", inj_out, 0);
        check("basic_done_busy", inj_busy, 1);
        check("basic_no_err", stroke_err, 0);
        allow_injection = 1'b0;
        step();
        check("basic_idle", inj_busy, 0);

        // Zero delay, width 4
        inj_delay = 8'd0; inj_width = 16'd4;
        allow_injection = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check("d0_pulse", inj_out, 1);
            step();
        end
        check("d0_end", inj_out, 0);
        allow_injection = 1'b0;
        step();
        check("d0_idle", inj_busy, 0);

        // Zero width: no pulse, busy until the window closes
        inj_width = 16'd0;
        allow_injection = 1'b1;
        step();
        check("w0_out", inj_out, 0);
        check("w0_busy", inj_busy, 1);
        repeat (3) step();
        check("w0_out_later", inj_out, 0);
        check("w0_busy_later", inj_busy, 1);
        allow_injection = 1'b0;
        step();
        check("w0_idle", inj_busy, 0);

        // Early close on ignition
        ign_delay = 8'd5; ign_dwell = 16'd7; stroke = 2'b10;
        allow_ignition = 1'b1;
        step();
        check("early_busy", ign_busy, 1);
        tick_after(3);
        tick_after(3);
        allow_ignition = 1'b0;
        step();
        check("early_missed", ign_missed, 1);
        check("early_out", ign_out, 0);
        check("early_idle", ign_busy, 0);
        step();
        check("early_missed_clr", ign_missed, 0);

        // Wrong stroke, then a correct rearm
        stroke = 2'b01; inj_delay = 8'd0; inj_width = 16'd2;
        allow_injection = 1'b1;
        step();
        check("ws_err", stroke_err, 1);
        check("ws_busy", inj_busy, 0);
        step();
        check("ws_err_clr", stroke_err, 0);
        allow_injection = 1'b0;
        step();
        stroke = 2'b00;
        allow_injection = 1'b1;
        step();
        check("ws_ok_busy", inj_busy, 1);
        check("ws_ok_out", inj_out, 1);
        check("ws_ok_no_err", stroke_err, 0);
        step();
        check("ws_ok_out2", inj_out, 1);
        step();
        check("ws_ok_end", inj_out, 0);
        allow_injection = 1'b0;
        step();

        // Abort with on=0 mid-pulse
        inj_width = 16'd10;
        allow_injection = 1'b1;
        step(); step(); step();
        check("abort_pre", inj_out, 1);
        on = 1'b0;
        step();
        check("abort_out", inj_out, 0);
        check("abort_busy", inj_busy, 0);
        check("abort_missed", inj_missed, 0);
        on = 1'b1;
        step();
        check("abort_no_rearm", inj_busy, 0);
        allow_injection = 1'b0;
        step();

        // Asynchronous reset mid-pulse, then re-arm from a held window
        allow_injection = 1'b1;
        step(); step();
        check("rstp_pre", inj_out, 1);
        reset_n = 1'b0;
        #1;
        check("rstp_async_out", inj_out, 0);
        check("rstp_async_busy", inj_busy, 0);
        #2;
        reset_n = 1'b1;
        step();
        check("rstp_rearm", inj_out, 1);
        allow_injection = 1'b0;
        step();
        check("rstp_no_trunc", inj_out, 1);
        repeat (10) step();
        check("rstp_end_out", inj_out, 0);
        check("rstp_end_idle", inj_busy, 0);

        // Concurrency: both channels use delay 2, with widths 8 and 30
        inj_delay = 8'd2; inj_width = 16'd8; ign_delay = 8'd2; ign_dwell = 16'd30;
        stroke = 2'b00; allow_injection = 1'b1;
        step();
        stroke = 2'b10; allow_ignition = 1'b1;
        step();
        check("cc_inj_busy", inj_busy, 1);
        check("cc_ign_busy", ign_busy, 1);
        check("cc_no_err", stroke_err, 0);
        tick_after(5);
        tick_after(5);
        for (int i = 0; i < 30; i++) begin
            check("cc_inj_out", inj_out, (i < 8) ? 1 : 0);
            check("cc_ign_out", ign_out, 1);
            step();
        end
        check("cc_ign_end", ign_out, 0);
        tick_after(3);
        tick_after(3);
        check("cc_no_second", inj_out, 0);
        check("cc_inj_done", inj_busy, 1);
        allow_injection = 1'b0; allow_ignition = 1'b0;
        step();
        check("cc_inj_idle", inj_busy, 0);
        check("cc_ign_idle", ign_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
